// File: rtl/noise_eater_sequencer.sv
// Noise-eater ADC/DAC sequencer: one conversion per programmable sample period,
// parallel read, hand-off to the loop filter, then a DAC strobe after a fixed latency.
module noise_eater_sequencer #(
   parameter int unsigned CNVST_LOW = 2,
   parameter int unsigned RD_LOW    = 3,
   parameter int unsigned LOOP_LAT  = 2,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        enable_i,
   input  logic [15:0] period_i,
   output logic        adc_cnvst_o,
   input  logic        adc_eoc_i,
   output logic        adc_cs_o,
   output logic        adc_rd_o,
   input  logic [15:0] adc_data_i,
   output logic [15:0] sample_o,
   output logic        sample_valid_o,
   output logic        dac_wr_o,
   output logic        timeout_err_o,
   input  logic        clr_err_i,
   output logic [7:0]  overruns_o,
   output logic [2:0]  state_o
);

   // sample_valid_o is a one-cycle strobe with no back-pressure (no ready);
   // sample_o holds its value until the next strobe.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CONV = 3'd1,
      S_WAIT = 3'd2,
      S_READ = 3'd3,
      S_PUB  = 3'd4,
      S_LAT  = 3'd5,
      S_DAC  = 3'd6
   } state_t;

   localparam logic [15:0] CNV_LAST = 16'(CNVST_LOW - 1);
   localparam logic [15:0] RD_LAST  = 16'(RD_LOW - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [15:0] LAT_LAST = 16'((LOOP_LAT > 1) ? LOOP_LAT - 2 : 0);

   state_t      state_q;
   logic [15:0] sub_q;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  ovr_q, ovr_d;
   logic        err_q, err_d;
   logic        cnvst_q, cs_q, rd_q, valid_q, dac_q;
   logic [15:0] sample_q;
   logic [15:0] period_m1;
   logic        tick, to_hit, ovr_inc;

   always_comb begin
      period_m1 = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
      tick      = enable_i && (cnt_q == 16'd0);
      if (!enable_i)
         cnt_d = 16'd0;
      else if (tick)
         cnt_d = period_m1;
      else
         cnt_d = cnt_q - 16'd1;
      to_hit  = (state_q == S_WAIT) && adc_eoc_i && (sub_q == TO_LAST);
      ovr_inc = tick && (state_q != S_IDLE);
      // A set or increment in the same cycle as a clear wins over the clear.
      if (ovr_inc)
         ovr_d = clr_err_i ? 8'd1 : ((ovr_q == 8'hFF) ? 8'hFF : ovr_q + 8'd1);
      else
         ovr_d = clr_err_i ? 8'd0 : ovr_q;
      err_d = to_hit ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         sub_q    <= 16'd0;
         cnt_q    <= 16'd0;
         ovr_q    <= 8'd0;
         err_q    <= 1'b0;
         cnvst_q  <= 1'b1;
         cs_q     <= 1'b1;
         rd_q     <= 1'b1;
         valid_q  <= 1'b0;
         dac_q    <= 1'b1;
         sample_q <= 16'd0;
      end else begin
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         err_q   <= err_d;
         valid_q <= 1'b0;
         dac_q   <= 1'b1;
         case (state_q)
            S_IDLE: if (tick) begin
               state_q <= S_CONV;
               cnvst_q <= 1'b0;
               sub_q   <= CNV_LAST;
            end
            S_CONV: if (sub_q == 16'd0) begin
               state_q <= S_WAIT;
               cnvst_q <= 1'b1;
               sub_q   <= 16'd0;
            end else begin
               sub_q <= sub_q - 16'd1;
            end
            // EOC is only looked at here, after CNVST has risen.
            S_WAIT: if (!adc_eoc_i) begin
               state_q <= S_READ;
               cs_q    <= 1'b0;
               rd_q    <= 1'b0;
               sub_q   <= RD_LAST;
            end else if (sub_q == TO_LAST) begin
               state_q <= S_IDLE;
            end else begin
               sub_q <= sub_q + 16'd1;
            end
            S_READ: if (sub_q == 16'd0) begin
               state_q  <= S_PUB;
               cs_q     <= 1'b1;
               rd_q     <= 1'b1;
               sample_q <= adc_data_i;
               valid_q  <= 1'b1;
            end else begin
               sub_q <= sub_q - 16'd1;
            end
            S_PUB: if (LOOP_LAT <= 1) begin
               state_q <= S_DAC;
               dac_q   <= 1'b0;
            end else begin
               state_q <= S_LAT;
               sub_q   <= LAT_LAST;
            end
            S_LAT: if (sub_q == 16'd0) begin
               state_q <= S_DAC;
               dac_q   <= 1'b0;
            end else begin
               sub_q <= sub_q - 16'd1;
            end
            S_DAC:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // state_o encoding: 0 IDLE, 1 CONV, 2 WAIT_EOC, 3 READ, 4 PUBLISH, 5 LAT, 6 DAC.
   assign state_o        = state_q;
   assign adc_cnvst_o    = cnvst_q;
   assign adc_cs_o       = cs_q;
   assign adc_rd_o       = rd_q;
   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign dac_wr_o       = dac_q;
   assign timeout_err_o  = err_q;
   assign overruns_o     = ovr_q;

endmodule
